// File: rtl/fpu_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_arbiter
//
// Shares one FPU between NUM_REQ requesters. In IDLE a round-robin search
// that starts at rr_q picks one requester. Its operands, rounding mode and
// operator are latched and presented to the FPU for as long as the
// operation runs (BUSY). The FPU result is then held in RESP and offered
// to the owning requester only, until that requester accepts it.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_i             per-requester operation request
//   op_a_i, op_b_i    packed operands, requester i at [i*C_OP +: C_OP]
//   rm_i, cmd_i       packed rounding mode / operator, same packing
//   gnt_o             one-hot grant; the winner's operands are taken this cycle
//   r_valid_o         one-hot result valid (owner only, RESP only)
//   r_ready_i         per-requester result accept (only the owner's bit counts)
//   r_data_o          shared result bus, zero outside RESP
//   fpu_op_a_o, fpu_op_b_o, fpu_rm_o, fpu_cmd_o, fpu_enable_o
//                     FPU request side, enable high only in BUSY
//   fpu_result_i, fpu_valid_i
//                     FPU response, only sampled in BUSY
//   busy_o            high whenever the arbiter is not IDLE
//   owner_o           index of the current / most recent owner
// ---------------------------------------------------------------------------
module fpu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int C_OP    = 32,
    parameter int C_RM    = 3,
    parameter int C_CMD   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*C_OP-1:0]    op_a_i,
    input  logic [NUM_REQ*C_OP-1:0]    op_b_i,
    input  logic [NUM_REQ*C_RM-1:0]    rm_i,
    input  logic [NUM_REQ*C_CMD-1:0]   cmd_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         r_valid_o,
    input  logic [NUM_REQ-1:0]         r_ready_i,
    output logic [C_OP-1:0]            r_data_o,
    output logic [C_OP-1:0]            fpu_op_a_o,
    output logic [C_OP-1:0]            fpu_op_b_o,
    output logic [C_RM-1:0]            fpu_rm_o,
    output logic [C_CMD-1:0]           fpu_cmd_o,
    output logic                       fpu_enable_o,
    input  logic [C_OP-1:0]            fpu_result_i,
    input  logic                       fpu_valid_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [C_OP-1:0]  op_a_q, op_a_d;
    logic [C_OP-1:0]  op_b_q, op_b_d;
    logic [C_RM-1:0]  rm_q, rm_d;
    logic [C_CMD-1:0] cmd_q, cmd_d;
    logic [C_OP-1:0]  res_q, res_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [C_OP-1:0]  sel_a, sel_b;
    logic [C_RM-1:0]  sel_rm;
    logic [C_CMD-1:0] sel_cmd;

    // (base + k) mod NUM_REQ for base < NUM_REQ and k < NUM_REQ; a single
    // conditional subtract is enough and also covers non-power-of-two counts.
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin search: first set request at rr_q, rr_q+1, ... wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_i[rot_idx(rr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = rot_idx(rr_q, k);
            end
        end
    end

    // Winner's operand slice out of the packed request buses.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_rm  = '0;
        sel_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_a   = op_a_i[i*C_OP +: C_OP];
                sel_b   = op_b_i[i*C_OP +: C_OP];
                sel_rm  = rm_i[i*C_RM +: C_RM];
                sel_cmd = cmd_i[i*C_CMD +: C_CMD];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rm_d         = rm_q;
        cmd_d        = cmd_q;
        res_d        = res_q;
        gnt_o        = '0;
        r_valid_o    = '0;
        r_data_o     = '0;
        fpu_enable_o = 1'b0;

        case (state_q)
            IDLE: begin
                // The grant is combinational, so it is also masked by rst_n:
                // nothing may be handed out while reset is held.
                if (win_found && rst_n) begin
                    gnt_o[win_idx] = 1'b1;
                    owner_d        = win_idx;
                    rr_d           = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    op_a_d         = sel_a;
                    op_b_d         = sel_b;
                    rm_d           = sel_rm;
                    cmd_d          = sel_cmd;
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                fpu_enable_o = 1'b1;
                if (fpu_valid_i) begin
                    res_d   = fpu_result_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                r_valid_o[owner_q] = 1'b1;
                r_data_o           = res_q;
                if (r_ready_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= '0;
            owner_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            rm_q    <= '0;
            cmd_q   <= '0;
            res_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            owner_q <= owner_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            rm_q    <= rm_d;
            cmd_q   <= cmd_d;
            res_q   <= res_d;
        end
    end

    // The FPU always sees the latched operands; they only change on a grant,
    // so they stay constant for the whole operation.
    assign fpu_op_a_o = op_a_q;
    assign fpu_op_b_o = op_b_q;
    assign fpu_rm_o   = rm_q;
    assign fpu_cmd_o  = cmd_q;
    assign busy_o     = (state_q != IDLE);
    assign owner_o    = owner_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_arbiter
//
// Scoreboard bench for fpu_arbiter (4 requesters, 32-bit operands).
// The stimulus side predicts every grant with a plain round-robin model over
// the request mask and computes the expected result from the winner's
// operands with a stub FPU function; the prediction goes into exp_q. A
// monitor pops exp_q when a grant appears and pops the pending queue when a
// result is handshaken. A stub FPU with configurable latency and a result
// consumer with configurable back-pressure complete the environment.
// ---------------------------------------------------------------------------
module tb_fpu_arbiter;

    localparam int N       = 4;
    localparam int OPW     = 32;
    localparam int RMW     = 3;
    localparam int CMDW    = 4;
    localparam logic [3:0] CMD_ADD = 4'd0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_i;
    logic [N*OPW-1:0]  op_a_i, op_b_i;
    logic [N*RMW-1:0]  rm_i;
    logic [N*CMDW-1:0] cmd_i;
    logic [N-1:0]      gnt_o, r_valid_o;
    logic [N-1:0]      r_ready_i = '0;
    logic [OPW-1:0]    r_data_o;
    logic [OPW-1:0]    fpu_op_a_o, fpu_op_b_o;
    logic [RMW-1:0]    fpu_rm_o;
    logic [CMDW-1:0]   fpu_cmd_o;
    logic              fpu_enable_o;
    logic [OPW-1:0]    fpu_result_i = '0;
    logic              fpu_valid_i = 1'b0;
    logic              busy_o;
    logic [1:0]        owner_o;

    fpu_arbiter #(.NUM_REQ(N), .C_OP(OPW), .C_RM(RMW), .C_CMD(CMDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .rm_i(rm_i), .cmd_i(cmd_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .fpu_op_a_o(fpu_op_a_o), .fpu_op_b_o(fpu_op_b_o), .fpu_rm_o(fpu_rm_o),
        .fpu_cmd_o(fpu_cmd_o), .fpu_enable_o(fpu_enable_o),
        .fpu_result_i(fpu_result_i), .fpu_valid_i(fpu_valid_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   oh;
        logic [OPW-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend_q[$];

    int checks = 0;
    int errors = 0;
    int fpu_lat = 2;
    int rdy_delay = 0;
    int spur_mode = 0;   // 0: no stray fpu_valid_i, 1: random, 2: always
    int model_rr = 0;
    int g_n;
    int g_cyc[8];
    logic [N-1:0] g_oh[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic fail_wait(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected DUT event did not happen within its cycle budget", name);
    endtask

    // Stub FPU: exact for the sample 1.0 + 2.0 add, an arbitrary mix of all
    // fields otherwise (enough to tell requesters and operations apart).
    function automatic logic [OPW-1:0] fpu_f(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                             input logic [RMW-1:0] rm, input logic [CMDW-1:0] cmd);
        if (cmd == CMD_ADD && a == 32'h3F800000 && b == 32'h40000000) begin
            return 32'h40400000;
        end
        return (a + {b[15:0], b[31:16]}) ^ {rm, cmd, 25'h0};
    endfunction

    // Round-robin reference: first set bit of m at rr, rr+1, ... mod N.
    function automatic int pick(input logic [N-1:0] m, input int rr);
        for (int k = 0; k < N; k++) begin
            if (m[(rr + k) % N]) begin
                return (rr + k) % N;
            end
        end
        return -1;
    endfunction

    task automatic push_exp(input logic [N-1:0] mask);
        exp_t e;
        int   w;
        w = pick(mask, model_rr);
        if (w >= 0) begin
            e.oh  = N'(1) << w;
            e.res = fpu_f(op_a_i[w*OPW +: OPW], op_b_i[w*OPW +: OPW],
                          rm_i[w*RMW +: RMW], cmd_i[w*CMDW +: CMDW]);
            exp_q.push_back(e);
            model_rr = (w + 1) % N;
        end
    endtask

    task automatic rand_ops();
        op_a_i = {$urandom, $urandom, $urandom, $urandom};
        op_b_i = {$urandom, $urandom, $urandom, $urandom};
        rm_i   = 12'($urandom);
        cmd_i  = 16'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_i = '0;
        model_rr = 0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy_o && n < 100);
        if (busy_o) fail_wait("wait_idle");
    endtask

    // One arbitrated operation from an idle arbiter; noise scrambles the
    // request/operand inputs while the operation is in flight.
    task automatic do_txn(input logic [N-1:0] mask, input bit noise);
        int n;
        @(negedge clk);
        rand_ops();
        req_i = mask;
        push_exp(mask);
        if (mask != '0) begin
            @(posedge clk);
            #1;
            chk("grant_taken", busy_o, 1'b1);
            n = 0;
            while (busy_o) begin
                if (noise) begin
                    req_i = N'($urandom);
                    rand_ops();
                end
                @(posedge clk);
                #1;
                n++;
                if (n > 60) begin
                    fail_wait("txn_idle");
                    break;
                end
            end
        end
    endtask

    // Hold a request mask until cnt grants were seen, recording when.
    task automatic run_held(input logic [N-1:0] mask, input int cnt);
        int cyc;
        @(negedge clk);
        rand_ops();
        req_i = mask;
        for (int k = 0; k < cnt; k++) push_exp(mask);
        g_n = 0;
        cyc = 0;
        while (g_n < cnt && cyc < 100) begin
            #1;
            if (gnt_o != '0) begin
                g_oh[g_n]  = gnt_o;
                g_cyc[g_n] = cyc;
                g_n++;
            end
            if (g_n < cnt) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (g_n < cnt) fail_wait("held_grants");
        @(negedge clk);
        req_i = '0;
        wait_idle();
    endtask

    // Stub FPU: answers fpu_lat cycles into an operation; optionally drives
    // stray valids whenever it is not enabled.
    initial begin
        int fc;
        fc = 0;
        forever begin
            @(negedge clk);
            if (fpu_enable_o) begin
                fc++;
                if (fc == fpu_lat) begin
                    fpu_valid_i  = 1'b1;
                    fpu_result_i = fpu_f(fpu_op_a_o, fpu_op_b_o, fpu_rm_o, fpu_cmd_o);
                end else begin
                    fpu_valid_i  = 1'b0;
                    fpu_result_i = $urandom;
                end
            end else begin
                fc = 0;
                fpu_valid_i  = (spur_mode == 2) || (spur_mode == 1 && $urandom_range(0, 3) == 0);
                fpu_result_i = $urandom;
            end
        end
    end

    // Result consumer: accepts after rdy_delay waiting cycles; bits of
    // requesters that have nothing offered toggle randomly.
    initial begin
        int rc;
        logic [N-1:0] rn;
        rc = 0;
        forever begin
            @(negedge clk);
            if (r_valid_o != '0) begin
                rn = N'($urandom) & ~r_valid_o;
                if (rc >= rdy_delay) rn = rn | r_valid_o;
                rc++;
            end else begin
                rn = N'($urandom);
                rc = 0;
            end
            r_ready_i = rn;
        end
    end

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        logic [N-1:0]   pv;
        logic [OPW-1:0] pd;
        bit hold;
        hold = 1'b0;
        pv = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pend_q.delete();
                hold = 1'b0;
            end else begin
                if (gnt_o != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", gnt_o, '0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant", gnt_o, e.oh);
                        pend_q.push_back(e);
                    end
                end
                if (r_valid_o != '0) begin
                    if (hold) begin
                        chk("resp_valid_stable", r_valid_o, pv);
                        chk("resp_data_stable", r_data_o, pd);
                    end
                    if ((r_valid_o & r_ready_i) != '0) begin
                        if (pend_q.size() == 0) begin
                            chk("unexpected_result", r_valid_o, '0);
                        end else begin
                            e = pend_q.pop_front();
                            chk("result_owner", r_valid_o, e.oh);
                            chk("result_data", r_data_o, e.res);
                        end
                        hold = 1'b0;
                    end else begin
                        hold = 1'b1;
                        pv = r_valid_o;
                        pd = r_data_o;
                    end
                end else begin
                    hold = 1'b0;
                    chk("r_data_idle", r_data_o, '0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]   m;
        logic [OPW-1:0] bp_exp;
        int n;

        // Reset state, with every requester asking.
        rst_n = 1'b0;
        req_i = '1;
        rand_ops();
        #3;
        chk("rst_gnt", gnt_o, '0);
        chk("rst_r_valid", r_valid_o, '0);
        chk("rst_r_data", r_data_o, '0);
        chk("rst_fpu_enable", fpu_enable_o, 1'b0);
        chk("rst_fpu_op_a", fpu_op_a_o, '0);
        chk("rst_fpu_op_b", fpu_op_b_o, '0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_owner", owner_o, '0);
        @(negedge clk);
        @(negedge clk);
        req_i = '0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt", gnt_o, '0);
        chk("post_rst_busy", busy_o, 1'b0);

        // Single request, latency 2.
        fpu_lat = 2;
        rdy_delay = 0;
        spur_mode = 0;
        @(negedge clk);
        rand_ops();
        op_a_i[63:32] = 32'h3F800000;
        op_b_i[63:32] = 32'h40000000;
        cmd_i[7:4]    = CMD_ADD;
        rm_i[5:3]     = '0;
        req_i = 4'b0010;
        push_exp(4'b0010);
        #1;
        chk("single_gnt_c0", gnt_o, 4'b0010);
        @(negedge clk);
        req_i = '0;
        #1;
        chk("single_en_c1", fpu_enable_o, 1'b1);
        chk("single_op_a_c1", fpu_op_a_o, 32'h3F800000);
        chk("single_owner_c1", owner_o, 2'd1);
        @(negedge clk);
        #1;
        chk("single_en_c2", fpu_enable_o, 1'b1);
        chk("single_op_b_c2", fpu_op_b_o, 32'h40000000);
        @(negedge clk);
        #1;
        chk("single_valid_c3", r_valid_o, 4'b0010);
        chk("single_data_c3", r_data_o, 32'h40400000);
        chk("single_en_c3", fpu_enable_o, 1'b0);
        @(negedge clk);
        #1;
        chk("single_idle_c4", busy_o, 1'b0);

        // Round-robin with all four requesting.
        do_reset();
        run_held(4'b1111, 5);
        for (int k = 0; k < 5; k++) chk("rr_order", g_oh[k], 4'b0001 << (k % 4));
        for (int k = 1; k < 5; k++) chk("rr_spacing", g_cyc[k] - g_cyc[k-1], 4);

        // Wrap and skip: pointer at 3, only 0 and 2 requesting.
        do_reset();
        do_txn(4'b0100, 1'b0);
        run_held(4'b0101, 2);
        chk("wrap_first", g_oh[0], 4'b0001);
        chk("wrap_second", g_oh[1], 4'b0100);

        // Back-pressure: five cycles without accept, then accept.
        do_reset();
        fpu_lat = 1;
        rdy_delay = 5;
        @(negedge clk);
        rand_ops();
        req_i = 4'b0001;
        push_exp(4'b0001);
        bp_exp = fpu_f(op_a_i[31:0], op_b_i[31:0], rm_i[2:0], cmd_i[3:0]);
        @(negedge clk);
        req_i = '0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (r_valid_o == '0 && n < 10);
        if (r_valid_o == '0) fail_wait("bp_resp");
        req_i = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid_hold", r_valid_o, 4'b0001);
            chk("bp_data_hold", r_data_o, bp_exp);
            chk("bp_no_grant", gnt_o, '0);
            chk("bp_fpu_idle", fpu_enable_o, 1'b0);
            @(negedge clk);
            #1;
        end
        req_i = '0;
        chk("bp_valid_c6", r_valid_o, 4'b0001);
        @(posedge clk);
        #1;
        chk("bp_idle_after_accept", busy_o, 1'b0);
        rdy_delay = 0;

        // Reset in the middle of an operation, then stray FPU valids.
        do_reset();
        fpu_lat = 8;
        @(negedge clk);
        rand_ops();
        req_i = 4'b0100;
        push_exp(4'b0100);
        @(negedge clk);
        req_i = '0;
        #1;
        chk("midrst_en_before", fpu_enable_o, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_en_drop", fpu_enable_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_owner", owner_o, '0);
        chk("midrst_op_a", fpu_op_a_o, '0);
        model_rr = 0;
        exp_q.delete();
        spur_mode = 2;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("midrst_no_valid", r_valid_o, '0);
            chk("midrst_stays_idle", busy_o, 1'b0);
        end
        spur_mode = 0;
        fpu_lat = 2;
        run_held(4'b1111, 1);
        chk("midrst_next_lowest", g_oh[0], 4'b0001);

        // Randomized traffic.
        spur_mode = 1;
        for (int t = 0; t < 150; t++) begin
            m = N'($urandom);
            if ($urandom_range(0, 5) == 0) m = '0;
            fpu_lat   = $urandom_range(1, 4);
            rdy_delay = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            do_txn(m, 1'b1);
        end
        @(negedge clk);
        req_i = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size() + pend_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one FPU (2..16).
REQ-002 SHALL have parameter C_OP, default 32, operand/result width.
REQ-003 SHALL have parameter C_RM, default 3, rounding-mode width.
REQ-004 SHALL have parameter C_CMD, default 4, operator width.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_i  input  NUM_REQ  per-requester operation request.
REQ-008 SHALL have port op_a_i, op_b_i  input  NUM_REQ*C_OP each  packed per-requester operands (requester i at bits [i*C_OP +: C_OP]).
REQ-009 SHALL have port rm_i  input  NUM_REQ*C_RM  and port cmd_i  input  NUM_REQ*C_CMD  packed rounding mode / operator.
REQ-010 SHALL have port gnt_o  output  NUM_REQ  one-hot grant, operands consumed this cycle.
REQ-011 SHALL have port r_valid_o  output  NUM_REQ  one-hot result valid; r_ready_i  input  NUM_REQ  result accept.
REQ-012 SHALL have port r_data_o  output  C_OP  result, shared by all requesters.
REQ-013 SHALL have ports fpu_op_a_o, fpu_op_b_o (C_OP), fpu_rm_o (C_RM), fpu_cmd_o (C_CMD), fpu_enable_o (1), all outputs, driving the FPU.
REQ-014 SHALL have ports fpu_result_i  input  C_OP  and fpu_valid_i  input  1  from the FPU.
REQ-015 SHALL have ports busy_o  output  1  (state != IDLE) and owner_o  output  $clog2(NUM_REQ)  current owner index.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP; reset state IDLE.
REQ-017 In IDLE with any req_i bit set, SHALL assert gnt_o combinationally for exactly one winner, chosen round-robin starting at pointer rr_q.
REQ-018 Winner SHALL be the first set req_i bit at index rr_q, rr_q+1, ... wrapping modulo NUM_REQ.
REQ-019 On grant SHALL register winner operands, rm, cmd into internal registers, load owner_q with winner index, set rr_q = (winner+1) mod NUM_REQ, go to BUSY.
REQ-020 gnt_o SHALL be all-zero outside IDLE and when req_i is zero; no grant to a requester whose req_i is 0.
REQ-021 In BUSY SHALL hold fpu_enable_o=1 and drive fpu_* outputs from the internal registers, constant for the whole operation; fpu_enable_o SHALL be 0 in IDLE and RESP.
REQ-022 In BUSY when fpu_valid_i=1 SHALL capture fpu_result_i into result register and go to RESP next cycle; fpu_valid_i outside BUSY SHALL be ignored.
REQ-023 In RESP SHALL assert r_valid_o[owner_q] only, with r_data_o = result register, held stable until r_ready_i[owner_q]=1.
REQ-024 On RESP handshake SHALL return to IDLE; r_ready_i bits of non-owners SHALL be ignored.
REQ-025 Minimum grant-to-grant spacing SHALL be: 1 (grant) + FPU latency + 1 (RESP with immediate ready) cycles; no new grant before return to IDLE.
REQ-026 req_i changes while BUSY/RESP SHALL not affect the current operation; a requester may drop req_i before grant without side effect.
REQ-027 owner_o SHALL equal owner_q; r_data_o SHALL be 0 outside RESP.

Reset
REQ-028 On rst_n=0 (asynchronous, any state, including mid-operation) SHALL force state IDLE, rr_q=0, owner_q=0, result and operand registers 0.
REQ-029 During and after reset until first grant: gnt_o=0, r_valid_o=0, r_data_o=0, fpu_enable_o=0, fpu_* operands 0, busy_o=0, owner_o=0.
REQ-030 An operation aborted by reset SHALL produce no r_valid_o; a late fpu_valid_i after reset SHALL be ignored.

Verification
REQ-031 Single request: req_i=4'b0010, a=0x3F800000, b=0x40000000, cmd=ADD, FPU latency 2 -> gnt_o=4'b0010 in cycle 0, fpu_enable_o high cycles 1-2, r_valid_o=4'b0010 with r_data_o=0x40400000 in cycle 3.
REQ-032 Round-robin: req_i=4'b1111 held, ready always 1 -> grant order 0,1,2,3,0, each grant 4 cycles apart.
REQ-033 Wrap/skip: rr_q=3 after grant to 2, req_i=4'b0101 -> next grant to 0, then to 2.
REQ-034 Back-pressure: r_ready_i=0 for 5 cycles in RESP -> r_valid_o and r_data_o stable 5 cycles, no gnt_o, fpu_enable_o=0; accept on cycle 6 -> IDLE next cycle.
REQ-035 Reset mid-BUSY: assert rst_n=0 while fpu_enable_o=1 -> fpu_enable_o=0 immediately, no r_valid_o, next grant after reset goes to lowest-index requester.
